mips_mc_main_ctrl: RTL and testbench

Multicycle MIPS main control FSM; sits directly upstream of the ALU control unit.
- Decodes opcode and sequences fetch/decode/execute/memory/writeback.
- Drives the datapath strobes and the 3-bit ALUOp consumed by the ALU control unit.
- Consumes that unit's JumpReg output to complete jr.

---
 rtl/mips_pkg.sv | 92 +++++++++
 rtl/mips_mc_out_decode.sv | 104 ++++++++++
 rtl/mips_mc_main_ctrl.sv | 97 +++++++++
 tb/tb_mips_mc_main_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALUOp codes,
// FSM state encodings, datapath mux selects and the DECODE dispatch helper.
package mips_pkg;

  localparam int OPC_W   = 6;
  localparam int STATE_W = 4;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_FUNC = 3'b010;
  localparam logic [2:0] ALUOP_AND  = 3'b011;
  localparam logic [2:0] ALUOP_OR   = 3'b100;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_JR        = 4'd9,
    S_BRANCH    = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_JUMP      = 4'd13,
    S_JAL       = 4'd14
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_ncond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // Unknown opcodes fall back to FETCH, which is also how illegal_op is recognised.
  function automatic state_e decode_next(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_RTYPE:               return S_R_EXEC;
      OP_LW, OP_SW:           return S_MEM_ADDR;
      OP_BEQ, OP_BNE:         return S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI: return S_I_EXEC;
      OP_J:                   return S_JUMP;
      OP_JAL:                 return S_JAL;
      default:                return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_out_decode.sv
// Combinational state -> datapath control decode for the multicycle MIPS FSM.
// With MC_MEM_WAIT_EN, FETCH gates pc_write/ir_write on mem_ready_i.
module mips_mc_out_decode
  import mips_pkg::*;
(
  input  state_e           state_i,
  input  logic [OPC_W-1:0] opcode_i,
`ifdef MC_MEM_WAIT_EN
  input  logic             mem_ready_i,
`endif
  output ctrl_t            ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
`ifdef MC_MEM_WAIT_EN
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
`else
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
`endif
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMMSH2;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = (decode_next(opcode_i) == S_FETCH);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = MTR_MDR;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNC;
      end
      S_R_WB: begin
        ctrl_o.reg_dst    = REGDST_RD;
        ctrl_o.mem_to_reg = MTR_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      S_JR: begin
        ctrl_o.pc_source = PCSRC_REG;
        ctrl_o.pc_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a      = 1'b1;
        ctrl_o.alu_src_b      = SRCB_B;
        ctrl_o.alu_op         = ALUOP_SUB;
        ctrl_o.pc_source      = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond  = (opcode_i == OP_BEQ);
        ctrl_o.pc_write_ncond = (opcode_i == OP_BNE);
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        case (opcode_i)
          OP_ANDI: ctrl_o.alu_op = ALUOP_AND;
          OP_ORI:  ctrl_o.alu_op = ALUOP_OR;
          default: ctrl_o.alu_op = ALUOP_ADD;
        endcase
      end
      S_I_WB: begin
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = MTR_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.pc_write  = 1'b1;
      end
      S_JAL: begin
        ctrl_o.reg_dst    = REGDST_RA;
        ctrl_o.mem_to_reg = MTR_PC;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.pc_write   = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_main_ctrl.sv
// Multicycle MIPS main control FSM (Moore); outputs decoded from the state register.
// Optional MC_MEM_WAIT_EN: FETCH/MEM_READ/MEM_WRITE wait for mem_ready_i.
module mips_mc_main_ctrl
  import mips_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic               jump_reg_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               pc_write_ncond_o,
  output logic               i_or_d_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic [1:0]         reg_dst_o,
  output logic [1:0]         mem_to_reg_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [2:0]         alu_op_o,
  output logic [1:0]         pc_source_o,
  output logic               illegal_op_o,
  output logic [STATE_W-1:0] state_o
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   mem_hold;

`ifdef MC_MEM_WAIT_EN
  assign mem_hold = !mem_ready_i;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready_i;
  assign mem_hold         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     state_d = mem_hold ? S_FETCH : S_DECODE;
      S_DECODE:    state_d = decode_next(opcode_i);
      S_MEM_ADDR:  state_d = (opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_hold ? S_MEM_READ : S_MEM_WB;
      S_MEM_WRITE: state_d = mem_hold ? S_MEM_WRITE : S_FETCH;
      // jump_reg_i is only trusted while ALUOp=FUNC, i.e. in R_EXEC.
      S_R_EXEC:    state_d = jump_reg_i ? S_JR : S_R_WB;
      S_MEM_WB, S_R_WB, S_JR, S_BRANCH, S_I_WB, S_JUMP, S_JAL:
                   state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  mips_mc_out_decode u_out_decode (
    .state_i     (state_q),
    .opcode_i    (opcode_i),
`ifdef MC_MEM_WAIT_EN
    .mem_ready_i (mem_ready_i),
`endif
    .ctrl_o      (ctrl)
  );

  assign pc_write_o       = ctrl.pc_write;
  assign pc_write_cond_o  = ctrl.pc_write_cond;
  assign pc_write_ncond_o = ctrl.pc_write_ncond;
  assign i_or_d_o         = ctrl.i_or_d;
  assign mem_read_o       = ctrl.mem_read;
  assign mem_write_o      = ctrl.mem_write;
  assign ir_write_o       = ctrl.ir_write;
  assign reg_dst_o        = ctrl.reg_dst;
  assign mem_to_reg_o     = ctrl.mem_to_reg;
  assign reg_write_o      = ctrl.reg_write;
  assign alu_src_a_o      = ctrl.alu_src_a;
  assign alu_src_b_o      = ctrl.alu_src_b;
  assign alu_op_o         = ctrl.alu_op;
  assign pc_source_o      = ctrl.pc_source;
  assign illegal_op_o     = ctrl.illegal_op;
  assign state_o          = state_q;

endmodule

// File: tb/tb_mips_mc_main_ctrl.sv
// Self-checking bench for mips_mc_main_ctrl: directed instructions then random opcodes,
// checked cycle by cycle against a per-instruction phase model.
module tb_mips_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode_i;
  logic       jump_reg_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, pc_write_ncond_o, i_or_d_o;
  logic       mem_read_o, mem_write_o, ir_write_o, reg_write_o, alu_src_a_o, illegal_op_o;
  logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int testsRun    = 0;
  int testsFailed = 0;
  int forcedStall = -1;
  string phases[$];

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcWriteNcond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       illegal;
  } ctrlVec_t;

  ctrlVec_t observed;

  always #5 clk = ~clk;

  mips_mc_main_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .opcode_i         (opcode_i),
    .jump_reg_i       (jump_reg_i),
    .mem_ready_i      (mem_ready_i),
    .pc_write_o       (pc_write_o),
    .pc_write_cond_o  (pc_write_cond_o),
    .pc_write_ncond_o (pc_write_ncond_o),
    .i_or_d_o         (i_or_d_o),
    .mem_read_o       (mem_read_o),
    .mem_write_o      (mem_write_o),
    .ir_write_o       (ir_write_o),
    .reg_dst_o        (reg_dst_o),
    .mem_to_reg_o     (mem_to_reg_o),
    .reg_write_o      (reg_write_o),
    .alu_src_a_o      (alu_src_a_o),
    .alu_src_b_o      (alu_src_b_o),
    .alu_op_o         (alu_op_o),
    .pc_source_o      (pc_source_o),
    .illegal_op_o     (illegal_op_o),
    .state_o          (state_o)
  );

  assign observed = {pc_write_o, pc_write_cond_o, pc_write_ncond_o, i_or_d_o, mem_read_o,
                     mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
                     alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o, illegal_op_o};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic bit isLegal(input logic [5:0] opc);
    return opc inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
  endfunction

  // Instruction -> ordered list of named control phases, straight from the instruction table.
  function automatic void buildPhases(input logic [5:0] opc, input bit jr);
    phases = {"FETCH", "DECODE"};
    case (opc)
      6'h23: phases = {phases, "MEM_ADDR", "MEM_READ", "MEM_WB"};
      6'h2B: phases = {phases, "MEM_ADDR", "MEM_WRITE"};
      6'h00: phases = {phases, "R_EXEC", jr ? "JR" : "R_WB"};
      6'h04, 6'h05: phases = {phases, "BRANCH"};
      6'h08, 6'h0C, 6'h0D: phases = {phases, "I_EXEC", "I_WB"};
      6'h02: phases = {phases, "JUMP"};
      6'h03: phases = {phases, "JAL"};
      default: ;
    endcase
  endfunction

  // Expected datapath strobes for one named phase.
  function automatic ctrlVec_t phaseVec(input string phase, input logic [5:0] opc, input bit memReady);
    ctrlVec_t v;
    v = '0;
    case (phase)
      "FETCH":     begin v.memRead = 1; v.irWrite = memReady; v.aluSrcB = 2'b01; v.pcWrite = memReady; end
      "DECODE":    begin v.aluSrcB = 2'b11; v.illegal = !isLegal(opc); end
      "MEM_ADDR":  begin v.aluSrcA = 1; v.aluSrcB = 2'b10; end
      "MEM_READ":  begin v.memRead = 1; v.iOrD = 1; end
      "MEM_WB":    begin v.memToReg = 2'b01; v.regWrite = 1; end
      "MEM_WRITE": begin v.memWrite = 1; v.iOrD = 1; end
      "R_EXEC":    begin v.aluSrcA = 1; v.aluOp = 3'b010; end
      "R_WB":      begin v.regDst = 2'b01; v.regWrite = 1; end
      "JR":        begin v.pcSource = 2'b11; v.pcWrite = 1; end
      "BRANCH":    begin
        v.aluSrcA = 1; v.aluOp = 3'b001; v.pcSource = 2'b01;
        v.pcWriteCond = (opc == 6'h04); v.pcWriteNcond = (opc == 6'h05);
      end
      "I_EXEC":    begin
        v.aluSrcA = 1; v.aluSrcB = 2'b10;
        v.aluOp = (opc == 6'h0C) ? 3'b011 : (opc == 6'h0D) ? 3'b100 : 3'b000;
      end
      "I_WB":      begin v.regWrite = 1; end
      "JUMP":      begin v.pcSource = 2'b10; v.pcWrite = 1; end
      "JAL":       begin v.regDst = 2'b10; v.memToReg = 2'b10; v.regWrite = 1; v.pcSource = 2'b10; v.pcWrite = 1; end
      default:     v = '0;
    endcase
    return v;
  endfunction

  // Assumes rst_n was just pulled low; leaves the bench at the negedge where FETCH begins.
  task automatic doReset();
    #1;
    checkOutput("reset_outputs", 32'(observed), 32'd0);
    checkOutput("reset_state", 32'(state_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_outputs", 32'(observed), 32'd0);
    checkOutput("idle_state", 32'(state_o), 32'd0);
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH; abortPhase >= 0 pulls reset in that phase.
  task automatic applyStimulus(input logic [5:0] opc, input bit jr, input int abortPhase);
    buildPhases(opc, jr);
    opcode_i = opc;
    foreach (phases[i]) begin
      int stalls = 0;
`ifdef MC_MEM_WAIT_EN
      if (phases[i] inside {"FETCH", "MEM_READ", "MEM_WRITE"})
        stalls = (forcedStall >= 0 && phases[i] == "FETCH") ? forcedStall : int'($urandom_range(0, 2));
`endif
      for (int s = 0; s <= stalls; s++) begin
        jump_reg_i = (phases[i] == "R_EXEC") ? jr : 1'($urandom);
`ifdef MC_MEM_WAIT_EN
        mem_ready_i = (s == stalls);
`else
        mem_ready_i = 1'($urandom);
`endif
        #1;
        if (i == abortPhase) begin
          checkOutput({"pre_abort_", phases[i]}, 32'(observed), 32'(phaseVec(phases[i], opc, s == stalls)));
          rst_n = 1'b0;
          doReset();
          return;
        end
        checkOutput(phases[i], 32'(observed), 32'(phaseVec(phases[i], opc, s == stalls)));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [5:0] legalOps [10];
    legalOps = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    rst_n       = 1'b0;
    opcode_i    = 6'h00;
    jump_reg_i  = 1'b0;
    mem_ready_i = 1'b0;
    doReset();

    forcedStall = 3;
    applyStimulus(6'h23, 1'b0, -1);
    forcedStall = -1;
    applyStimulus(6'h00, 1'b0, -1);
    applyStimulus(6'h00, 1'b1, -1);
    applyStimulus(6'h05, 1'b0, -1);
    applyStimulus(6'h04, 1'b0, -1);
    applyStimulus(6'h0D, 1'b0, -1);
    applyStimulus(6'h3F, 1'b0, -1);
    applyStimulus(6'h2B, 1'b0, 3);
    applyStimulus(6'h03, 1'b0, -1);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] opc;
      if ($urandom_range(0, 4) == 0) opc = 6'($urandom);
      else opc = legalOps[$urandom_range(0, 9)];
      applyStimulus(opc, 1'($urandom), -1);
    end

    mem_ready_i = 1'b1;
    #1;
    checkOutput("final_fetch", 32'(observed), 32'(phaseVec("FETCH", 6'h00, 1'b1)));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
